intersection_scan_unit: RTL and testbench

INTERSECTION_SCAN_UNIT -- requirements
Module: intersection_scan_unit

---
 rtl/intersection_scan_unit.sv | 157 +++++++++++++++
 tb/tb_intersection_scan_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intersection_scan_unit.sv
// Scans a stream of triangles against one latched ray and reports the nearest qualifying hit.
// Intersection results pass through a PIPE-deep register pipeline; tri_ready throttles the stream.
module intersection_scan_unit #(
  parameter int         MAX_TRIS = 64,
  parameter int         IDX_W    = $clog2(MAX_TRIS),
  parameter int         PIPE     = 2,
  parameter int         OF       = 0,
  parameter logic [1:0] HIT_CODE = 2'b01,
  parameter int         FIX_W    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [3*FIX_W-1:0]      ray_in,
  input  logic [IDX_W:0]          tri_count,
  input  logic                    tri_valid,
  input  logic [5*FIX_W-1:0]      tri_data,
  output logic                    tri_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    hit,
  output logic signed [FIX_W-1:0] hit_t,
  output logic [IDX_W-1:0]        hit_idx,
  output logic [1:0]              hit_code
);

  // ray_in packs {ox, oy, oz}; tri_data packs {x0, x1, y0, y1, z}; all signed fixed point.
  typedef logic signed [FIX_W-1:0] fixed_t;

  typedef struct packed {
    fixed_t ox;
    fixed_t oy;
    fixed_t oz;
  } ray_t;

  typedef struct packed {
    fixed_t x0;
    fixed_t x1;
    fixed_t y0;
    fixed_t y1;
    fixed_t z;
  } tri_t;

  typedef struct packed {
    fixed_t     t;
    logic [1:0] code;
  } res_t;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
    fixed_t           t;
    logic [1:0]       code;
  } stage_t;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [IDX_W:0] MAX_CNT = (IDX_W+1)'(MAX_TRIS);

  // Ray travels along +z; the triangle is its xy bounding rectangle at depth z.
  // Code 01: origin inside the rectangle, 10: outside, 00: degenerate rectangle.
  function automatic res_t functionIntersectionTest(input ray_t r, input tri_t tr, input int of);
    res_t res;
    res.t = tr.z - r.oz + fixed_t'(of);
    if (tr.x0 > tr.x1 || tr.y0 > tr.y1)
      res.code = 2'b00;
    else if (r.ox >= tr.x0 && r.ox <= tr.x1 && r.oy >= tr.y0 && r.oy <= tr.y1)
      res.code = 2'b01;
    else
      res.code = 2'b10;
    return res;
  endfunction

  logic [1:0]     state;
  ray_t           ray_q;
  logic [IDX_W:0] cnt_q;
  logic [IDX_W:0] acc_cnt;
  stage_t         pipe [PIPE];
  stage_t         out;
  res_t           res;
  logic           accept;
  logic           last_accept;
  logic           drain_end;
  logic           t_pos;
  logic           take;

  assign res         = functionIntersectionTest(ray_q, tri_t'(tri_data), OF);
  assign tri_ready   = (state == S_SCAN) && (acc_cnt < cnt_q);
  assign accept      = tri_valid && tri_ready;
  assign last_accept = accept && (acc_cnt == cnt_q - 1'b1);
  assign out         = pipe[PIPE-1];
  assign drain_end   = out.vld && ({1'b0, out.idx} == cnt_q - 1'b1);
  assign t_pos       = !out.t[FIX_W-1] && (out.t != '0);
  // Results arrive in index order, so a strict compare keeps the lowest index on ties.
  assign take        = out.vld && (out.code == HIT_CODE) && t_pos && (!hit || out.t < hit_t);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE; i++) pipe[i] <= '0;
    end else begin
      pipe[0].vld  <= accept;
      pipe[0].idx  <= acc_cnt[IDX_W-1:0];
      pipe[0].t    <= res.t;
      pipe[0].code <= res.code;
      for (int i = 1; i < PIPE; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ray_q    <= '0;
      cnt_q    <= '0;
      acc_cnt  <= '0;
      hit      <= 1'b0;
      hit_t    <= '0;
      hit_idx  <= '0;
      hit_code <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            ray_q    <= ray_t'(ray_in);
            cnt_q    <= (tri_count > MAX_CNT) ? MAX_CNT : tri_count;
            acc_cnt  <= '0;
            hit      <= 1'b0;
            hit_t    <= '0;
            hit_idx  <= '0;
            hit_code <= 2'b00;
            state    <= (tri_count == '0) ? S_DONE : S_SCAN;
          end
        end
        S_SCAN: begin
          if (accept) acc_cnt <= acc_cnt + 1'b1;
          if (last_accept) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (drain_end) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase

      if (take && (state == S_SCAN || state == S_DRAIN)) begin
        hit      <= 1'b1;
        hit_t    <= out.t;
        hit_idx  <= out.idx;
        hit_code <= out.code;
      end
    end
  end

endmodule

// File: tb/tb_intersection_scan_unit.sv
// Bench for intersection_scan_unit: directed and random scans, scoreboard of expected results
// pushed at issue time and popped by a monitor whenever done pulses.
module tb_intersection_scan_unit;

  localparam int         MAX_TRIS = 64;
  localparam int         IDX_W    = 6;
  localparam int         PIPE     = 2;
  localparam int         OF       = 0;
  localparam logic [1:0] HIT_CODE = 2'b01;
  localparam int         FIX_W    = 32;
  localparam int         ONE      = 65536;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [3*FIX_W-1:0]      ray_in;
  logic [IDX_W:0]          tri_count;
  logic                    tri_valid;
  logic [5*FIX_W-1:0]      tri_data;
  logic                    tri_ready;
  logic                    busy;
  logic                    done;
  logic                    hit;
  logic signed [FIX_W-1:0] hit_t;
  logic [IDX_W-1:0]        hit_idx;
  logic [1:0]              hit_code;

  intersection_scan_unit #(
    .MAX_TRIS(MAX_TRIS), .IDX_W(IDX_W), .PIPE(PIPE), .OF(OF), .HIT_CODE(HIT_CODE), .FIX_W(FIX_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ray_in(ray_in), .tri_count(tri_count),
    .tri_valid(tri_valid), .tri_data(tri_data), .tri_ready(tri_ready), .busy(busy),
    .done(done), .hit(hit), .hit_t(hit_t), .hit_idx(hit_idx), .hit_code(hit_code)
  );

  always #5 clk = ~clk;

  typedef struct { int ox; int oy; int oz; } ray_s;
  typedef struct { int x0; int x1; int y0; int y1; int z; } tri_s;
  typedef struct { bit h; int t; int idx; int code; int cyc; } exp_s;

  exp_s exp_q[$];
  exp_s last_exp;
  exp_s mon_e;
  tri_s ts[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Nearest positive-t hit with the required code; first one wins on equal t.
  function automatic exp_s model(input ray_s r, input tri_s q[$]);
    exp_s e;
    int   t;
    int   code;
    e = '{0, 0, 0, 0, 0};
    for (int i = 0; i < q.size(); i++) begin
      t = q[i].z - r.oz + OF;
      if (q[i].x0 > q[i].x1 || q[i].y0 > q[i].y1) code = 0;
      else if (r.ox >= q[i].x0 && r.ox <= q[i].x1 && r.oy >= q[i].y0 && r.oy <= q[i].y1) code = 1;
      else code = 2;
      if (code == int'(HIT_CODE) && t > 0 && (!e.h || t < e.t)) begin
        e.h = 1; e.t = t; e.idx = i; e.code = code;
      end
    end
    return e;
  endfunction

  function automatic tri_s make_tri(input ray_s r, input int t, input int kind);
    tri_s s;
    s.z = r.oz + t - OF;
    s.y0 = r.oy - ONE;
    s.y1 = r.oy + ONE;
    case (kind)
      0:       begin s.x0 = r.ox - ONE;     s.x1 = r.ox + ONE;     end
      1:       begin s.x0 = r.ox + 2 * ONE; s.x1 = r.ox + 3 * ONE; end
      2:       begin s.x0 = r.ox + ONE;     s.x1 = r.ox - ONE;     end
      default: begin s.x0 = r.ox;           s.x1 = r.ox + ONE;  s.y1 = r.oy; end
    endcase
    return s;
  endfunction

  function automatic ray_s rand_ray();
    ray_s r;
    r.ox = int'($urandom_range(0, 200 * ONE)) - 100 * ONE;
    r.oy = int'($urandom_range(0, 200 * ONE)) - 100 * ONE;
    r.oz = int'($urandom_range(0, 200 * ONE)) - 100 * ONE;
    return r;
  endfunction

  function automatic logic [3*FIX_W-1:0] pack_ray(input ray_s r);
    return {r.ox, r.oy, r.oz};
  endfunction

  function automatic logic [5*FIX_W-1:0] pack_tri(input tri_s s);
    return {s.x0, s.x1, s.y0, s.y1, s.z};
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_tri_ready"}, tri_ready, 0);
    chk({tag, "_hit"}, hit, 0);
    chk({tag, "_hit_t"}, hit_t, 0);
    chk({tag, "_hit_idx"}, hit_idx, 0);
    chk({tag, "_hit_code"}, hit_code, 0);
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1, expected done=0 (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("done_cycle", cyc, mon_e.cyc);
        chk("hit", hit, mon_e.h);
        chk("hit_t", hit_t, mon_e.t);
        chk("hit_idx", hit_idx, mon_e.idx);
        chk("hit_code", hit_code, mon_e.code);
      end
    end
  end

  // Called at a negedge; offers ts[] to the unit and pushes the expected result on issue.
  task automatic run_scan(input ray_s r, input int cnt_req, input int vpct,
                          input bit repulse, input int abort_at);
    tri_s sub[$];
    exp_s e;
    int   eff;
    int   acc;
    int   extra;
    int   guard;
    bit   acc_now;
    eff = (cnt_req > MAX_TRIS) ? MAX_TRIS : cnt_req;
    for (int i = 0; i < eff; i++) sub.push_back(ts[i]);
    e = model(r, sub);

    chk("hold_hit", hit, last_exp.h);
    chk("hold_hit_t", hit_t, last_exp.t);
    chk("hold_hit_idx", hit_idx, last_exp.idx);
    chk("hold_hit_code", hit_code, last_exp.code);

    start = 1'b1;
    ray_in = pack_ray(r);
    tri_count = (IDX_W+1)'(cnt_req);
    if (eff == 0) begin
      e.cyc = cyc + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    start = 1'b0;
    ray_in = {$urandom, $urandom, $urandom};
    tri_count = (IDX_W+1)'($urandom_range(0, 127));

    acc = 0;
    guard = 0;
    while (acc < eff && guard < 1000) begin
      start = repulse && (guard == 1);
      tri_valid = ($urandom_range(0, 99) < vpct);
      tri_data = tri_valid ? pack_tri(sub[acc]) : {5{$urandom}};
      acc_now = tri_valid && tri_ready;
      if (acc_now) begin
        acc++;
        if (acc == eff) begin
          e.cyc = cyc + 1 + PIPE;
          exp_q.push_back(e);
        end
      end
      @(negedge clk);
      guard++;
      if (abort_at > 0 && acc == abort_at) begin
        start = 1'b0;
        rst = 1'b1;
        tri_valid = 1'b0;
        @(negedge clk);
        check_zero("abort_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (PIPE + 4) @(negedge clk);
        check_zero("abort_after");
        last_exp = '{0, 0, 0, 0, 0};
        return;
      end
    end
    start = 1'b0;
    chk("accepted", acc, eff);

    tri_valid = 1'b1;
    extra = 0;
    repeat (PIPE + 3) begin
      tri_data = {5{$urandom}};
      if (tri_ready) extra++;
      @(negedge clk);
    end
    tri_valid = 1'b0;
    chk("accept_count", acc + extra, eff);

    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      chk("done_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    last_exp = e;
  endtask

  task automatic add(input ray_s r, input int t, input int kind);
    ts.push_back(make_tri(r, t, kind));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish by 500000");
    $fatal(1, "timeout");
  end

  initial begin
    ray_s r;
    int   n;
    rst = 1'b1;
    start = 1'b0;
    tri_valid = 1'b0;
    ray_in = '0;
    tri_count = '0;
    tri_data = '0;
    last_exp = '{0, 0, 0, 0, 0};
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Distinct t, valid held high: nearest is 2.0 at index 1.
    r = rand_ray();
    ts.delete();
    add(r, 5 * ONE, 0); add(r, 2 * ONE, 0); add(r, 7 * ONE, 0); add(r, 3 * ONE, 0);
    run_scan(r, 4, 100, 0, 0);

    // Equal t keeps index 0; then non-positive t values are skipped.
    r = rand_ray();
    ts.delete();
    add(r, 4 * ONE, 0); add(r, 4 * ONE, 3); add(r, 4 * ONE, 0);
    run_scan(r, 3, 100, 0, 0);
    ts.delete();
    add(r, -ONE, 0); add(r, 0, 0); add(r, 6 * ONE, 0);
    run_scan(r, 3, 100, 0, 0);

    // No qualifying codes.
    r = rand_ray();
    ts.delete();
    add(r, ONE, 1); add(r, 2 * ONE, 2); add(r, 3 * ONE, 1);
    run_scan(r, 3, 100, 0, 0);

    // Empty scan, then an over-long count clamps to MAX_TRIS.
    run_scan(rand_ray(), 0, 100, 0, 0);
    r = rand_ray();
    ts.delete();
    for (int i = 0; i < MAX_TRIS; i++) add(r, int'($urandom_range(1, 40)) * (ONE / 4), 0);
    run_scan(r, MAX_TRIS + 10, 100, 0, 0);

    // Random stalls with a start re-pulsed mid-scan.
    r = rand_ray();
    ts.delete();
    for (int i = 0; i < 5; i++) add(r, int'($urandom_range(0, 16)) * (ONE / 2) - 4 * ONE, int'($urandom_range(0, 3)));
    run_scan(r, 5, 50, 1, 0);

    // Reset after the second accept abandons the scan; a fresh scan then completes.
    r = rand_ray();
    ts.delete();
    for (int i = 0; i < 4; i++) add(r, (i + 1) * ONE, 0);
    run_scan(r, 4, 100, 0, 2);
    run_scan(r, 4, 100, 0, 0);

    for (int k = 0; k < 20; k++) begin
      r = rand_ray();
      n = ($urandom_range(0, 9) == 0) ? 70 : int'($urandom_range(0, 12));
      ts.delete();
      for (int i = 0; i < ((n > MAX_TRIS) ? MAX_TRIS : n); i++)
        add(r, int'($urandom_range(0, 16)) * (ONE / 2) - 4 * ONE, int'($urandom_range(0, 3)));
      run_scan(r, n, int'($urandom_range(30, 100)), bit'($urandom_range(0, 1)), 0);
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
